music_tone_gen: RTL and testbench

// - Downstream of the melody note ROM. Converts the 5-bit note index (1..21, 0 = rest) into a square wave that drives the board buzzer.
// - Samples a new note on each beat pulse from the beat counter, which also steps the ROM address.
// - Inserts a short silent gap between repeated identical notes, so held notes and re-struck notes sound distinct.

---
 rtl/music_tone_gen.sv | 156 +++++++++++++++
 tb/tb_music_tone_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/music_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module      : music_tone_gen
//  Description : Converts a 5-bit melody note index into a square wave for
//                the board buzzer. A new note is taken on each beat pulse,
//                and a silent gap separates re-struck identical notes.
//  Revision    : 1.0 - initial release
// ============================================================================
module music_tone_gen #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int GAP_CYCLES = 500_000,
   parameter int DIV_W      = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       beat,
   input  logic [4:0] note,
   output logic       buzzer,
   output logic       note_active,
   output logic [4:0] cur_note
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GAP  = 2'd1,
      S_TONE = 2'd2
   } state_t;

   // Tone frequencies in Hz for note indices 1..21; anything else is silence.
   function automatic int note_freq(input int idx);
      case (idx)
         1:  note_freq = 262;   2:  note_freq = 294;   3:  note_freq = 330;
         4:  note_freq = 349;   5:  note_freq = 392;   6:  note_freq = 440;
         7:  note_freq = 494;   8:  note_freq = 523;   9:  note_freq = 587;
         10: note_freq = 659;   11: note_freq = 698;   12: note_freq = 784;
         13: note_freq = 880;   14: note_freq = 988;   15: note_freq = 1047;
         16: note_freq = 1175;  17: note_freq = 1319;  18: note_freq = 1397;
         19: note_freq = 1568;  20: note_freq = 1760;  21: note_freq = 1976;
         default: note_freq = 0;
      endcase
   endfunction

   logic [DIV_W-1:0] w_half_tab [0:31];

   // Half-period table, fully resolved at elaboration so no runtime divider.
   for (genvar gi = 0; gi < 32; gi++) begin : g_half
      localparam int C_F    = note_freq(gi);
      localparam int C_HALF = (C_F == 0) ? 0 : CLK_HZ / (2 * C_F);
      assign w_half_tab[gi] = DIV_W'(C_HALF);
   end

   state_t           r_state, w_state_nx;
   logic [4:0]       r_cur_note, w_cur_note_nx;
   logic [DIV_W-1:0] r_half, w_half_nx;
   logic [DIV_W-1:0] r_div_cnt, w_div_cnt_nx;
   logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nx;
   logic             r_buzzer, w_buzzer_nx;
   logic             w_note_valid;

   assign w_note_valid = (note != 5'd0) && (note <= 5'd21);

   // State and datapath registers; reset and play-disable both clear everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cur_note <= '0;
         r_half     <= '0;
         r_div_cnt  <= '0;
         r_gap_cnt  <= '0;
         r_buzzer   <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_cur_note <= w_cur_note_nx;
         r_half     <= w_half_nx;
         r_div_cnt  <= w_div_cnt_nx;
         r_gap_cnt  <= w_gap_cnt_nx;
         r_buzzer   <= w_buzzer_nx;
      end
   end

   // Next-state logic: en=0 beats beat; a beat is evaluated in every state.
   always_comb begin
      w_state_nx    = r_state;
      w_cur_note_nx = r_cur_note;
      w_half_nx     = r_half;
      w_div_cnt_nx  = r_div_cnt;
      w_gap_cnt_nx  = r_gap_cnt;
      w_buzzer_nx   = r_buzzer;

      if (!en) begin
         w_state_nx    = S_IDLE;
         w_cur_note_nx = '0;
         w_div_cnt_nx  = '0;
         w_gap_cnt_nx  = '0;
         w_buzzer_nx   = 1'b0;
      end else if (beat && !w_note_valid) begin
         w_state_nx    = S_IDLE;
         w_cur_note_nx = '0;
         w_div_cnt_nx  = '0;
         w_gap_cnt_nx  = '0;
         w_buzzer_nx   = 1'b0;
      end else if (beat && (note != r_cur_note)) begin
         w_state_nx    = S_TONE;
         w_cur_note_nx = note;
         w_half_nx     = w_half_tab[note];
         w_div_cnt_nx  = '0;
         w_gap_cnt_nx  = '0;
         w_buzzer_nx   = 1'b0;
      end else if (beat && (GAP_CYCLES > 0)) begin
         // Re-struck identical note: go quiet briefly before restarting.
         w_state_nx   = S_GAP;
         w_div_cnt_nx = '0;
         w_gap_cnt_nx = '0;
         w_buzzer_nx  = 1'b0;
      end else begin
         // No beat, or a repeated note with the gap disabled: keep running.
         case (r_state)
            S_GAP: begin
               if (r_gap_cnt == C_GAP_LAST) begin
                  w_state_nx   = S_TONE;
                  w_gap_cnt_nx = '0;
                  w_div_cnt_nx = '0;
                  w_buzzer_nx  = 1'b0;
               end else begin
                  w_gap_cnt_nx = r_gap_cnt + GAP_W'(1);
               end
            end
            S_TONE: begin
               if (r_div_cnt == r_half - DIV_W'(1)) begin
                  w_div_cnt_nx = '0;
                  w_buzzer_nx  = ~r_buzzer;
               end else begin
                  w_div_cnt_nx = r_div_cnt + DIV_W'(1);
               end
            end
            default: begin
               w_state_nx    = S_IDLE;
               w_cur_note_nx = '0;
               w_div_cnt_nx  = '0;
               w_gap_cnt_nx  = '0;
               w_buzzer_nx   = 1'b0;
            end
         endcase
      end
   end

   assign buzzer      = r_buzzer;
   assign note_active = (r_state == S_TONE);
   assign cur_note    = r_cur_note;

endmodule
`default_nettype wire

// File: tb/tb_music_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_music_tone_gen
//  Description : Self-checking bench for music_tone_gen. A timeline model
//                (elapsed time since tone start, divided by half-period)
//                predicts the outputs every cycle; directed scenarios add
//                literal timing expectations, then random beats follow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_music_tone_gen;

   localparam int CLK_HZ = 1_000_000;
   localparam int GAP    = 16;
   localparam int DIV_W  = 20;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       en   = 1'b1;
   logic       beat = 1'b1;
   logic [4:0] note = 5'd0;
   wire        buzzer;
   wire        note_active;
   wire  [4:0] cur_note;

   int checks = 0;
   int errors = 0;

   music_tone_gen #(
      .CLK_HZ    (CLK_HZ),
      .GAP_CYCLES(GAP),
      .DIV_W     (DIV_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .beat       (beat),
      .note       (note),
      .buzzer     (buzzer),
      .note_active(note_active),
      .cur_note   (cur_note)
   );

   always #5 clk = ~clk;

   int freq [0:21] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698,
                       784, 880, 988, 1047, 1175, 1319, 1397, 1568, 1760, 1976};

   // Model: mode 0 silent, 1 gap, 2 tone; m_t = cycles since tone started.
   int  m_mode = 0;
   int  m_note = 0;
   int  m_t    = 0;
   int  m_g    = 0;
   bit  started = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model advances once per clock from the inputs in effect.
   always @(posedge clk) begin
      started = 1'b1;
      if (rst || !en) begin
         m_mode = 0; m_note = 0; m_t = 0; m_g = 0;
      end else if (beat) begin
         if (note == 0 || note > 21) begin
            m_mode = 0; m_note = 0;
         end else if (int'(note) != m_note) begin
            m_mode = 2; m_note = note; m_t = 0;
         end else begin
            m_mode = 1; m_g = 0;
         end
      end else if (m_mode == 1) begin
         if (m_g == GAP - 1) begin m_mode = 2; m_t = 0; end
         else m_g++;
      end else if (m_mode == 2) begin
         m_t++;
      end
   end

   // Every-cycle comparison against the model, on the falling edge.
   always @(negedge clk) begin
      if (started) begin
         int half;
         logic exp_buz;
         half    = (m_note >= 1 && m_note <= 21) ? CLK_HZ / (2 * freq[m_note]) : 1;
         exp_buz = (m_mode == 2) && (((m_t / half) % 2) == 1);
         chk("buzzer",      32'(buzzer),      32'(exp_buz));
         chk("note_active", 32'(note_active), 32'(m_mode == 2));
         chk("cur_note",    32'(cur_note),    32'(m_note));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_beat(input int n);
      note = 5'(n);
      beat = 1'b1;
      step(1);
      beat = 1'b0;
   endtask

   // Cycles until buzzer reaches level v (bounded).
   task automatic wait_buzz(input logic v, output int c);
      c = 0;
      while (buzzer !== v && c < 5000) begin
         step(1);
         c++;
      end
   endtask

   initial begin
      int c;
      // 1 Reset held with en and beat asserted.
      note = 5'd13;
      step(3);
      chk("reset_buzzer", 32'(buzzer), 0);
      chk("reset_active", 32'(note_active), 0);
      chk("reset_note", 32'(cur_note), 0);
      rst = 1'b0; beat = 1'b0;
      step(2);

      // 2 Single note 13: rise after 568, fall 568 later.
      do_beat(13);
      chk("t2_cur_note", 32'(cur_note), 13);
      wait_buzz(1'b1, c); chk("t2_rise_568", c, 568);
      wait_buzz(1'b0, c); chk("t2_fall_568", c, 568);

      // 3 Note 8 then 15: phase restarts on the change edge.
      do_beat(8);
      wait_buzz(1'b1, c); chk("t3_rise_956", c, 956);
      do_beat(15);
      chk("t3_change_buzzer", 32'(buzzer), 0);
      chk("t3_cur_note", 32'(cur_note), 15);
      wait_buzz(1'b1, c); chk("t3_rise_477", c, 477);

      // 4 Repeated note: 16 silent cycles then tone restarts.
      do_beat(13);
      step(700);
      do_beat(13);
      chk("t4_gap_buzzer", 32'(buzzer), 0);
      c = 0;
      while (note_active !== 1'b1 && c < 100) begin step(1); c++; end
      chk("t4_gap_len_16", c, 16);
      wait_buzz(1'b1, c); chk("t4_restart_568", c, 568);

      // 5 Rest and invalid note.
      do_beat(0);
      chk("t5_rest_note", 32'(cur_note), 0);
      chk("t5_rest_buzzer", 32'(buzzer), 0);
      do_beat(3);
      step(50);
      do_beat(25);
      chk("t5_invalid_note", 32'(cur_note), 0);
      chk("t5_invalid_active", 32'(note_active), 0);

      // 6 en drop mid-tone.
      do_beat(13);
      step(600);
      en = 1'b0;
      step(1);
      chk("t6_en_buzzer", 32'(buzzer), 0);
      chk("t6_en_note", 32'(cur_note), 0);
      beat = 1'b1; step(9); beat = 1'b0;
      en = 1'b1;
      step(50);
      chk("t6_silent_after_en", 32'(note_active), 0);
      do_beat(13);
      wait_buzz(1'b1, c); chk("t6_rise_568", c, 568);

      // Randomized beats, repeats, rests, invalid notes, en drops, resets.
      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            rst = 1'b1; step($urandom_range(1, 3)); rst = 1'b0;
         end else if (r == 1) begin
            en = 1'b0; step($urandom_range(1, 20)); en = 1'b1;
         end else begin
            int k, n;
            k = $urandom_range(0, 9);
            if (k < 4)       n = int'(cur_note == 0 ? 5'd7 : cur_note);
            else if (k == 4) n = 0;
            else if (k == 5) n = $urandom_range(22, 31);
            else             n = $urandom_range(1, 21);
            do_beat(n);
         end
         for (int j = 0; j < 4; j++) begin
            note = 5'($urandom_range(0, 31));
            step($urandom_range(1, 600));
         end
      end

      step(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
